// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the write-back stage: default widths, halt FSM
// encoding and the hard-wired zero register index.
package wb_regfile_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NREGS_DEF  = 32;
    localparam int unsigned CNT_W_DEF  = 32;

    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Register storage: two combinational read ports, one synchronous write port,
// same-cycle write-through bypass; register 0 reads as zero.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra1_i,
    input  logic [ADDR_W-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != ZERO_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        if (ra == ZERO_IDX) begin
            return '0;
        end else if (we && (ra == wa)) begin
            return wd;
        end else begin
            return stored;
        end
    endfunction

    assign rd1_o = read_port(ra1_i, wr_en, waddr_i, wdata_i, regs_q[ra1_i]);
    assign rd2_o = read_port(ra2_i, wr_en, waddr_i, wdata_i, regs_q[ra2_i]);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects ALU/load result, commits it to the register file,
// stops committing once a halt-marked instruction retires, counts commits.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic              flag,
    input  logic [DATA_W-1:0] salida,
    input  logic [DATA_W-1:0] dato,
    input  logic [ADDR_W-1:0] AW,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic              halted,
    output logic [CNT_W-1:0]  wb_count
);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign wb_data = memtoreg ? dato : salida;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // The halting instruction still commits; only later ones are blocked.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flag) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wb_we  = 1'b0;
        halted = 1'b0;
        unique case (state_q)
            RUN:     wb_we  = regwrite && (AW != ADDR_W'(REG_ZERO));
            HALTED:  halted = 1'b1;
            default: wb_we  = 1'b0;
        endcase
    end

    assign count_d = wb_we ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign wb_count = count_q;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wb_we),
        .waddr_i (AW),
        .wdata_i (wb_data),
        .ra1_i   (ra1),
        .ra2_i   (ra2),
        .rd1_o   (rd1),
        .rd2_o   (rd2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with the retired-write counter narrowed to 4 bits.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              regwrite;
    logic              memtoreg;
    logic              flag;
    logic [DATA_W-1:0] salida;
    logic [DATA_W-1:0] dato;
    logic [ADDR_W-1:0] AW;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic              halted;
    logic [CNT_W-1:0]  wb_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .regwrite (regwrite),
        .memtoreg (memtoreg),
        .flag     (flag),
        .salida   (salida),
        .dato     (dato),
        .AW       (AW),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wb_data  (wb_data),
        .wb_we    (wb_we),
        .halted   (halted),
        .wb_count (wb_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; regwrite = 1'b0; memtoreg = 1'b0; flag = 1'b0;
        salida = '0; dato = '0; AW = '0; ra1 = '0; ra2 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        ra1 = 5; ra2 = 31; #1;
        check("rst_rd1", rd1, 32'h0);
        check("rst_rd2", rd2, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_count", {28'b0, wb_count}, 32'h0);

        // ALU write with same-cycle bypass
        tick();
        regwrite = 1; memtoreg = 0; salida = 32'hDEADBEEF; AW = 7; ra1 = 7; ra2 = 0; #1;
        check("byp_rd1", rd1, 32'hDEADBEEF);
        check("byp_wbdata", wb_data, 32'hDEADBEEF);
        check("byp_we", {31'b0, wb_we}, 32'h1);
        check("byp_rd2_zero", rd2, 32'h0);
        tick();
        regwrite = 0; #1;
        check("r7_after", rd1, 32'hDEADBEEF);
        check("cnt1", {28'b0, wb_count}, 32'd1);
        check("we_idle", {31'b0, wb_we}, 32'h0);

        // Load-data write
        regwrite = 1; memtoreg = 1; dato = 32'h12345678; salida = 32'hFFFFFFFF; AW = 3; ra2 = 3; #1;
        check("ld_wbdata", wb_data, 32'h12345678);
        check("ld_byp_rd2", rd2, 32'h12345678);
        tick();
        regwrite = 0; memtoreg = 0; #1;
        check("r3_after", rd2, 32'h12345678);
        check("cnt2", {28'b0, wb_count}, 32'd2);

        // Write to register 0 is dropped
        regwrite = 1; salida = 32'hAAAA5555; AW = 0; ra1 = 0; #1;
        check("r0_we", {31'b0, wb_we}, 32'h0);
        check("r0_rd1", rd1, 32'h0);
        tick();
        regwrite = 0; #1;
        check("r0_rd1_after", rd1, 32'h0);
        check("cnt_r0", {28'b0, wb_count}, 32'd2);

        // Dual bypass on both ports
        regwrite = 1; salida = 32'h0000CAFE; AW = 12; ra1 = 12; ra2 = 12; #1;
        check("dual_rd1", rd1, 32'h0000CAFE);
        check("dual_rd2", rd2, 32'h0000CAFE);
        tick();
        regwrite = 0; ra2 = 7; #1;
        check("r12", rd1, 32'h0000CAFE);
        check("r7_still", rd2, 32'hDEADBEEF);
        check("cnt3", {28'b0, wb_count}, 32'd3);

        // Halt: flagged write still commits
        regwrite = 1; salida = 32'h1; AW = 9; ra1 = 9; tick();
        salida = 32'h2; flag = 1; #1;
        check("pre_halt", {31'b0, halted}, 32'h0);
        tick();
        regwrite = 0; flag = 0; #1;
        check("halted", {31'b0, halted}, 32'h1);
        check("r9_halt", rd1, 32'h2);
        check("cnt5", {28'b0, wb_count}, 32'd5);
        regwrite = 1; salida = 32'h3; AW = 9; #1;
        check("halt_we", {31'b0, wb_we}, 32'h0);
        check("halt_nobyp", rd1, 32'h2);
        tick();
        regwrite = 0; #1;
        check("r9_frozen", rd1, 32'h2);
        check("cnt_frozen", {28'b0, wb_count}, 32'd5);
        check("still_halted", {31'b0, halted}, 32'h1);

        // Reset while halted, with a write presented
        rst = 1; regwrite = 1; AW = 4; salida = 32'h55; tick();
        rst = 0; regwrite = 0; ra1 = 4; ra2 = 7; #1;
        check("post_rst_r4", rd1, 32'h0);
        check("post_rst_r7", rd2, 32'h0);
        check("post_rst_halted", {31'b0, halted}, 32'h0);
        check("post_rst_cnt", {28'b0, wb_count}, 32'h0);
        ra1 = 9; ra2 = 3; #1;
        check("post_rst_r9", rd1, 32'h0);
        check("post_rst_r3", rd2, 32'h0);

        // Counter wrap: 15 writes reach 15, the 16th wraps to 0
        for (int k = 1; k <= 15; k++) begin
            regwrite = 1; AW = 5'(k); salida = 32'(k * 16); tick();
        end
        regwrite = 0; #1;
        check("cnt15", {28'b0, wb_count}, 32'd15);
        regwrite = 1; AW = 16; salida = 32'h77; tick();
        regwrite = 0; ra1 = 16; ra2 = 15; #1;
        check("cnt_wrap", {28'b0, wb_count}, 32'd0);
        check("r16", rd1, 32'h77);
        check("r15", rd2, 32'd240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage of the 5-stage pipeline. Sits directly downstream of the MEM/WB pipeline register.
- Selects the write-back value: ALU result or memory load data.
- Commits that value into the 32-entry register file and serves the two decode-stage read ports, with same-cycle write-through bypass.
- Tracks a halt condition carried down the pipeline on flag, and counts retired register writes for debug.

Parameters:
- DATA_W, 32, datapath and register width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers (2**ADDR_W)
- CNT_W, 32, width of retired-write counter

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- regwrite  in  1  write-back enable from MEM/WB register
- memtoreg  in  1  1 = write dato, 0 = write salida
- flag  in  1  halt marker travelling with the instruction
- salida  in  DATA_W  ALU result from MEM/WB register
- dato  in  DATA_W  load data from MEM/WB register
- AW  in  ADDR_W  destination register index
- ra1  in  ADDR_W  decode read address, port 1
- ra2  in  ADDR_W  decode read address, port 2
- rd1  out  DATA_W  read data, port 1 (combinational)
- rd2  out  DATA_W  read data, port 2 (combinational)
- wb_data  out  DATA_W  selected write-back value (combinational, for forwarding unit)
- wb_we  out  1  effective write enable this cycle (combinational)
- halted  out  1  registered, 1 once a halt has retired
- wb_count  out  CNT_W  registered count of committed register writes

Behaviour:
- Reset is synchronous and active-high. On a rising clk with rst=1:
  - all NREGS registers := 0
  - halted := 0
  - wb_count := 0
  - state := RUN
  - rst dominates every other input in that cycle.
- wb_data = memtoreg ? dato : salida. Pure mux, no latency.
- wb_we = regwrite & (AW != 0) & (state == RUN).
- Register write: at the rising edge, if wb_we then reg[AW] := wb_data. Write latency is one edge.
- Register 0 always reads 0. Writes to AW=0 are dropped and do not increment wb_count.
- Read ports:
  - rdN = 0 if raN == 0.
  - else rdN = wb_data if wb_we and raN == AW (write-through bypass, same cycle).
  - else rdN = reg[raN].
  - Both ports may hit the same register, and both may bypass simultaneously.
- wb_count: increments by 1 on every edge where wb_we=1. Wraps from 2**CNT_W-1 to 0 with no saturation.
- State machine, states RUN and HALTED:
  - RUN: if regwrite/flag arrive with flag=1, that instruction's write (if any) still commits on this edge. Next state is HALTED and halted := 1 on the same edge.
  - HALTED: wb_we is forced 0. No register writes, no count increments, flag ignored. Read ports remain fully functional (no bypass, since wb_we=0). Leaves HALTED only via rst.
- Reset mid-operation: a write presented in the same cycle as rst is discarded. Registers read 0 in the following cycle.
- No back-pressure. The block accepts one write-back per cycle, unconditionally, while in RUN.

Decomposition:
- Shared package: DATA_W, ADDR_W, NREGS defaults, the state encoding (RUN=0, HALTED=1), and the constant for register 0 index.
- One natural sub-module: regfile_2r1w. It holds the storage array with 2 combinational read ports, 1 synchronous write port, synchronous reset, and internal bypass.
- wb_regfile wraps regfile_2r1w and adds the write-back mux, halt FSM and counter.

Test Plan:
- Reset, then read ra1=5, ra2=31 -> rd1=0, rd2=0, halted=0, wb_count=0.
- regwrite=1, memtoreg=0, salida=32'hDEADBEEF, AW=7, with ra1=7 in the same cycle -> rd1=32'hDEADBEEF (bypass) and wb_data=32'hDEADBEEF. Next cycle with regwrite=0 -> rd1 still 32'hDEADBEEF, wb_count=1.
- regwrite=1, memtoreg=1, dato=32'h12345678, salida=32'hFFFFFFFF, AW=3 -> reg3=32'h12345678. Then AW=0 with any data -> ra1=0 reads 0 and wb_count is unchanged.
- Write reg9=32'h1, then regwrite=1, flag=1, AW=9, salida=32'h2 -> reg9=32'h2, halted=1. Subsequent write to AW=9 with 32'h3 -> reg9 stays 32'h2, wb_count frozen.
- While halted with registers populated, assert rst for one cycle alongside regwrite=1, AW=4, salida=32'h55 -> all registers 0, reg4=0, halted=0, wb_count=0.
- Force wb_count to 2**CNT_W-1 (CNT_W overridden to 4 -> value 15), perform one write -> wb_count=0.
